// File: rtl/y86_decode_regfile_if.sv
// Decode/write-back bus between fetch/execute/memory and the Y86-64 register file.
// master: the pipeline side that supplies instruction fields and write-back data.
// slave:  the register file, which returns selected IDs and operand values.
interface y86_decode_regfile_if #(
    parameter int unsigned DATA_W = 64
);
    // Instruction fields from fetch
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        rA;
    logic [3:0]        rB;
    // Write-back controls and data
    logic              cnd;
    logic              wb_en;
    logic [DATA_W-1:0] valE;
    logic [DATA_W-1:0] valM;
    // Operands and selected register IDs
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;
    logic [3:0]        srcA;
    logic [3:0]        srcB;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
    logic              icode_err;

    modport master (
        output icode, ifun, rA, rB, cnd, wb_en, valE, valM,
        input  valA, valB, srcA, srcB, dstE, dstM, icode_err
    );

    modport slave (
        input  icode, ifun, rA, rB, cnd, wb_en, valE, valM,
        output valA, valB, srcA, srcB, dstE, dstM, icode_err
    );
endinterface

// File: rtl/y86_decode_regfile.sv
// Y86-64 SEQ decode / write-back stage: 15 x DATA_W register file plus source and
// destination register selection. Reads are combinational; writes of valE/valM land
// on the rising clock edge when wb_en is set.
// Optional feature: define WB_BYPASS_EN to forward same-cycle write data to valA/valB.
module y86_decode_regfile #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned NREGS  = 15
) (
    input logic                 clk,
    input logic                 rst_n,
    y86_decode_regfile_if.slave bus
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    typedef enum logic [3:0] {
        IHalt   = 4'h0,
        INop    = 4'h1,
        IRrmovq = 4'h2,
        IIrmovq = 4'h3,
        IRmmovq = 4'h4,
        IMrmovq = 4'h5,
        IOpq    = 4'h6,
        IJxx    = 4'h7,
        ICall   = 4'h8,
        IRet    = 4'h9,
        IPushq  = 4'hA,
        IPopq   = 4'hB
    } icode_e;

    logic [DATA_W-1:0] regs [NREGS];

    logic [3:0]        srcA;
    logic [3:0]        srcB;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
    logic              icodeErr;
    logic [DATA_W-1:0] readA;
    logic [DATA_W-1:0] readB;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;

    // Select source/destination register IDs from the instruction fields
    always_comb begin
        srcA     = RNONE;
        srcB     = RNONE;
        dstE     = RNONE;
        dstM     = RNONE;
        icodeErr = (bus.icode > IPopq);
        case (bus.icode)
            IRrmovq: begin
                srcA = bus.rA;
                // ifun 0 is unconditional rrmovq; cmovXX only writes when taken
                if (bus.ifun == 4'h0 || bus.cnd) begin
                    dstE = bus.rB;
                end
            end
            IIrmovq: begin
                dstE = bus.rB;
            end
            IRmmovq: begin
                srcA = bus.rA;
                srcB = bus.rB;
            end
            IMrmovq: begin
                srcB = bus.rB;
                dstM = bus.rA;
            end
            IOpq: begin
                srcA = bus.rA;
                srcB = bus.rB;
                dstE = bus.rB;
            end
            ICall: begin
                srcB = RSP;
                dstE = RSP;
            end
            IRet: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
            end
            IPushq: begin
                srcA = bus.rA;
                srcB = RSP;
                dstE = RSP;
            end
            IPopq: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
                dstM = bus.rA;
            end
            // halt, nop, jXX and invalid codes touch no registers
            default: begin
            end
        endcase
    end

    // Register array: async clear, write-back of valE then valM so valM wins on a tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wb_en) begin
            if (dstE != RNONE) begin
                regs[dstE] <= bus.valE;
            end
            if (dstM != RNONE) begin
                regs[dstM] <= bus.valM;
            end
        end
    end

    // Combinational read of stored contents; RNONE reads as zero
    always_comb begin
        readA = '0;
        readB = '0;
        if (srcA != RNONE) begin
            readA = regs[srcA];
        end
        if (srcB != RNONE) begin
            readB = regs[srcB];
        end
    end

`ifdef WB_BYPASS_EN
    // Forward same-cycle write data to the read ports, valM ahead of valE
    always_comb begin
        valA = readA;
        valB = readB;
        if (rst_n && bus.wb_en) begin
            if (srcA != RNONE) begin
                if (srcA == dstM) begin
                    valA = bus.valM;
                end else if (srcA == dstE) begin
                    valA = bus.valE;
                end
            end
            if (srcB != RNONE) begin
                if (srcB == dstM) begin
                    valB = bus.valM;
                end else if (srcB == dstE) begin
                    valB = bus.valE;
                end
            end
        end
    end
`else
    // Read ports always return stored register contents
    always_comb begin
        valA = readA;
        valB = readB;
    end
`endif

    assign bus.srcA      = srcA;
    assign bus.srcB      = srcB;
    assign bus.dstE      = dstE;
    assign bus.dstM      = dstM;
    assign bus.icode_err = icodeErr;
    assign bus.valA      = valA;
    assign bus.valB      = valB;

endmodule

// File: tb/tb_y86_decode_regfile.sv
// Self-checking bench for y86_decode_regfile: directed scenarios plus randomized
// instruction streams against an array-based model of the architectural registers.
module tb_y86_decode_regfile;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [63:0] mregs [15];

    y86_decode_regfile_if #(.DATA_W(64)) bus ();

    y86_decode_regfile #(
        .DATA_W(64),
        .NREGS (15)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [3:0] m_srcA(logic [3:0] ic, logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_srcB(logic [3:0] ic, logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dstE(logic [3:0] ic, logic [3:0] fn, logic c,
                                          logic [3:0] rb);
        if (ic inside {4'h3, 4'h6}) return rb;
        if (ic == 4'h2 && (fn == 4'h0 || c)) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dstM(logic [3:0] ic, logic [3:0] ra);
        if (ic inside {4'h5, 4'hB}) return ra;
        return 4'hF;
    endfunction

    // Expected operand value for a source ID given the current inputs
    function automatic logic [63:0] m_val(logic [3:0] src, logic [3:0] de, logic [3:0] dm);
        if (!rst_n || src == 4'hF) return 64'h0;
`ifdef WB_BYPASS_EN
        if (bus.wb_en) begin
            if (src == dm) return bus.valM;
            if (src == de) return bus.valE;
        end
`endif
        return mregs[src];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic c, input logic we,
                         input logic [63:0] ve, input logic [63:0] vm);
        bus.icode = ic;
        bus.ifun  = fn;
        bus.rA    = ra;
        bus.rB    = rb;
        bus.cnd   = c;
        bus.wb_en = we;
        bus.valE  = ve;
        bus.valM  = vm;
        #3;
    endtask

    // Advance one clock edge, applying the model's write-back for the current inputs
    task automatic tick();
        logic [3:0] de;
        logic [3:0] dm;
        de = m_dstE(bus.icode, bus.ifun, bus.cnd, bus.rB);
        dm = m_dstM(bus.icode, bus.rA);
        @(posedge clk);
        if (rst_n && bus.wb_en) begin
            if (de != 4'hF) mregs[de] = bus.valE;
            if (dm != 4'hF) mregs[dm] = bus.valM;
        end
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 15; i++) mregs[i] = 64'h0;
        drive(4'h6, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0, 64'h0, 64'h0);
        repeat (2) tick();
        checks++;
        if (bus.valA !== 64'h0 || bus.valB !== 64'h0) begin
            errors++;
            $display("FAIL reset_vals: valA=%h valB=%h want 0/0", bus.valA, bus.valB);
        end
        checks++;
        if (bus.srcA !== 4'h0 || bus.srcB !== 4'h1 || bus.dstE !== 4'h1) begin
            errors++;
            $display("FAIL reset_ids: srcA=%h srcB=%h dstE=%h want 0/1/1",
                     bus.srcA, bus.srcB, bus.dstE);
        end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_irmovq();
        drive(4'h3, 4'h0, 4'hF, 4'h2, 1'b0, 1'b1, 64'h1234, 64'h0);
        checks++;
        if (bus.dstE !== 4'h2 || bus.srcA !== 4'hF || bus.srcB !== 4'hF
            || bus.dstM !== 4'hF) begin
            errors++;
            $display("FAIL irmovq_ids: dstE=%h srcA=%h srcB=%h dstM=%h want 2/F/F/F",
                     bus.dstE, bus.srcA, bus.srcB, bus.dstM);
        end
        tick();
        drive(4'h6, 4'h0, 4'h2, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        checks++;
        if (bus.valA !== 64'h1234) begin
            errors++;
            $display("FAIL irmovq_readback: valA=%h want 1234", bus.valA);
        end
    endtask

    task automatic test_popq_rsp();
        logic [63:0] exp;
        drive(4'h3, 4'h0, 4'hF, 4'h4, 1'b0, 1'b1, 64'h100, 64'h0);
        tick();
        drive(4'hB, 4'h0, 4'h4, 4'hF, 1'b0, 1'b1, 64'h8, 64'hAA);
        checks++;
        if (bus.srcA !== 4'h4 || bus.srcB !== 4'h4 || bus.dstE !== 4'h4
            || bus.dstM !== 4'h4) begin
            errors++;
            $display("FAIL popq_ids: srcA=%h srcB=%h dstE=%h dstM=%h want 4/4/4/4",
                     bus.srcA, bus.srcB, bus.dstE, bus.dstM);
        end
`ifdef WB_BYPASS_EN
        exp = 64'hAA;
`else
        exp = 64'h100;
`endif
        checks++;
        if (bus.valA !== exp) begin
            errors++;
            $display("FAIL popq_valA: valA=%h want %h", bus.valA, exp);
        end
        tick();
        drive(4'h6, 4'h0, 4'h4, 4'h4, 1'b0, 1'b0, 64'h0, 64'h0);
        checks++;
        if (bus.valA !== 64'hAA) begin
            errors++;
            $display("FAIL popq_valM_wins: regs[4]=%h want aa", bus.valA);
        end
    endtask

    task automatic test_cmov();
        drive(4'h3, 4'h0, 4'hF, 4'h3, 1'b0, 1'b1, 64'h33, 64'h0);
        tick();
        drive(4'h2, 4'h1, 4'h1, 4'h3, 1'b0, 1'b1, 64'hDEAD, 64'h0);
        checks++;
        if (bus.dstE !== 4'hF || bus.srcA !== 4'h1) begin
            errors++;
            $display("FAIL cmov_not_taken_ids: dstE=%h srcA=%h want F/1", bus.dstE, bus.srcA);
        end
        tick();
        drive(4'h6, 4'h0, 4'h3, 4'h3, 1'b0, 1'b0, 64'h0, 64'h0);
        checks++;
        if (bus.valA !== 64'h33) begin
            errors++;
            $display("FAIL cmov_not_taken_reg: regs[3]=%h want 33", bus.valA);
        end
        drive(4'h2, 4'h1, 4'h1, 4'h3, 1'b1, 1'b1, 64'hBEEF, 64'h0);
        checks++;
        if (bus.dstE !== 4'h3) begin
            errors++;
            $display("FAIL cmov_taken_dstE: dstE=%h want 3", bus.dstE);
        end
        tick();
        drive(4'h2, 4'h0, 4'h1, 4'h6, 1'b0, 1'b1, 64'h66, 64'h0);
        checks++;
        if (bus.dstE !== 4'h6) begin
            errors++;
            $display("FAIL rrmovq_uncond_dstE: dstE=%h want 6", bus.dstE);
        end
        tick();
        drive(4'h6, 4'h0, 4'h3, 4'h6, 1'b0, 1'b0, 64'h0, 64'h0);
        checks++;
        if (bus.valA !== 64'hBEEF || bus.valB !== 64'h66) begin
            errors++;
            $display("FAIL cmov_taken_regs: valA=%h valB=%h want beef/66", bus.valA, bus.valB);
        end
    endtask

    task automatic test_invalid();
        drive(4'h2, 4'h0, 4'hF, 4'h1, 1'b0, 1'b0, 64'h0, 64'h0);
        checks++;
        if (bus.valA !== 64'h0 || bus.srcA !== 4'hF) begin
            errors++;
            $display("FAIL rnone_read: valA=%h srcA=%h want 0/F", bus.valA, bus.srcA);
        end
        for (int ic = 12; ic < 16; ic++) begin
            drive(4'(ic), 4'h0, 4'h1, 4'h2, 1'b1, 1'b1, 64'hE0E0, 64'hF0F0);
            checks++;
            if (bus.icode_err !== 1'b1 || bus.srcA !== 4'hF || bus.srcB !== 4'hF
                || bus.dstE !== 4'hF || bus.dstM !== 4'hF || bus.valA !== 64'h0
                || bus.valB !== 64'h0) begin
                errors++;
                $display("FAIL invalid_icode_%0h: err=%b ids=%h%h%h%h valA=%h valB=%h want 1 FFFF 0 0",
                         ic, bus.icode_err, bus.srcA, bus.srcB, bus.dstE, bus.dstM,
                         bus.valA, bus.valB);
            end
            tick();
        end
        drive(4'h6, 4'h0, 4'h1, 4'h2, 1'b0, 1'b0, 64'h0, 64'h0);
        checks++;
        if (bus.valA !== mregs[1] || bus.valB !== mregs[2] || bus.icode_err !== 1'b0) begin
            errors++;
            $display("FAIL invalid_no_write: valA=%h valB=%h err=%b want %h/%h/0",
                     bus.valA, bus.valB, bus.icode_err, mregs[1], mregs[2]);
        end
    endtask

    task automatic test_bypass();
        logic [63:0] exp;
        drive(4'h3, 4'h0, 4'hF, 4'h5, 1'b0, 1'b1, 64'h55, 64'h0);
        tick();
        drive(4'h6, 4'h0, 4'h5, 4'h5, 1'b0, 1'b1, 64'h7, 64'h0);
`ifdef WB_BYPASS_EN
        exp = 64'h7;
`else
        exp = 64'h55;
`endif
        checks++;
        if (bus.valA !== exp || bus.valB !== exp) begin
            errors++;
            $display("FAIL bypass_same_cycle: valA=%h valB=%h want %h", bus.valA, bus.valB, exp);
        end
        tick();
    endtask

    task automatic test_reset_midrun();
        for (int i = 0; i < 15; i++) begin
            drive(4'h3, 4'h0, 4'hF, 4'(i), 1'b0, 1'b1, {32'hA5A5_0000, 32'(i + 1)}, 64'h0);
            tick();
        end
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 15; i++) mregs[i] = 64'h0;
        for (int i = 0; i < 15; i++) begin
            drive(4'h6, 4'h0, 4'(i), 4'(i), 1'b0, 1'b1, 64'hFFFF, 64'h0);
            checks++;
            if (bus.valA !== 64'h0 || bus.valB !== 64'h0) begin
                errors++;
                $display("FAIL midrun_reset_reg%0d: valA=%h valB=%h want 0", i, bus.valA, bus.valB);
            end
            tick();
        end
        rst_n = 1'b1;
        drive(4'h3, 4'h0, 4'hF, 4'h9, 1'b0, 1'b1, 64'h99, 64'h0);
        tick();
        drive(4'h6, 4'h0, 4'h9, 4'h8, 1'b0, 1'b0, 64'h0, 64'h0);
        checks++;
        if (bus.valA !== 64'h99 || bus.valB !== 64'h0) begin
            errors++;
            $display("FAIL reset_release_write: valA=%h valB=%h want 99/0", bus.valA, bus.valB);
        end
    endtask

    task automatic test_random();
        logic [3:0]  ic;
        logic [3:0]  eSrcA;
        logic [3:0]  eSrcB;
        logic [3:0]  eDstE;
        logic [3:0]  eDstM;
        logic [63:0] eValA;
        logic [63:0] eValB;
        for (int n = 0; n < 400; n++) begin
            ic = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15))
                                             : 4'($urandom_range(0, 11));
            drive(ic, 4'($urandom_range(0, 6)), 4'($urandom), 4'($urandom),
                  1'($urandom), ($urandom_range(0, 3) != 0),
                  {$urandom, $urandom}, {$urandom, $urandom});
            eSrcA = m_srcA(bus.icode, bus.rA);
            eSrcB = m_srcB(bus.icode, bus.rB);
            eDstE = m_dstE(bus.icode, bus.ifun, bus.cnd, bus.rB);
            eDstM = m_dstM(bus.icode, bus.rA);
            eValA = m_val(eSrcA, eDstE, eDstM);
            eValB = m_val(eSrcB, eDstE, eDstM);
            checks++;
            if (bus.srcA !== eSrcA || bus.srcB !== eSrcB || bus.dstE !== eDstE
                || bus.dstM !== eDstM || bus.icode_err !== (ic > 4'hB)) begin
                errors++;
                $display("FAIL rand_ids[%0d] icode=%h: got %h%h%h%h err=%b want %h%h%h%h",
                         n, ic, bus.srcA, bus.srcB, bus.dstE, bus.dstM, bus.icode_err,
                         eSrcA, eSrcB, eDstE, eDstM);
            end
            checks++;
            if (bus.valA !== eValA || bus.valB !== eValB) begin
                errors++;
                $display("FAIL rand_vals[%0d] icode=%h: valA=%h valB=%h want %h/%h",
                         n, ic, bus.valA, bus.valB, eValA, eValB);
            end
            tick();
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_irmovq();
        test_popq_rsp();
        test_cmov();
        test_invalid();
        test_bypass();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
